// File: rtl/hazard_if.sv
// Hazard-unit control bundle: ID/EX pipeline status in, stall/flush/freeze controls and statistics out.
// Combinational controls, registered FSM and statistics; dmem_busy freezes the whole pipeline.
interface hazard_if;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_rs_used;
    logic        id_rt_used;
    logic        ex_wb_write_en;
    logic        ex_wb_data_sel;
    logic [4:0]  ex_wb_addr;
    logic        ex_PC_sel;
    logic        dmem_busy;
    logic        clr_stats;
    logic        pc_write_en;
    logic        ifid_write_en;
    logic        ifid_flush;
    logic        idex_flush;
    logic        pipe_freeze;
    logic [1:0]  hazard_state;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    modport master (
        output id_rs, id_rt, id_rs_used, id_rt_used,
               ex_wb_write_en, ex_wb_data_sel, ex_wb_addr,
               ex_PC_sel, dmem_busy, clr_stats,
        input  pc_write_en, ifid_write_en, ifid_flush, idex_flush,
               pipe_freeze, hazard_state, stall_cycles, flush_events
    );

    modport slave (
        input  id_rs, id_rt, id_rs_used, id_rt_used,
               ex_wb_write_en, ex_wb_data_sel, ex_wb_addr,
               ex_PC_sel, dmem_busy, clr_stats,
        output pc_write_en, ifid_write_en, ifid_flush, idex_flush,
               pipe_freeze, hazard_state, stall_cycles, flush_events
    );
endinterface

// File: rtl/hazard_unit.sv
// Pipeline hazard control: load-use bubbles, branch flushes, memory-busy freeze; controls are same-cycle.
// dmem_busy holds FSM, down-counter and all pipeline registers; statistics saturate at 16'hFFFF.
module hazard_unit #(
    parameter int LOAD_STALL   = 1,
    parameter int BRANCH_FLUSH = 2
) (
    input  logic     clk,
    input  logic     reset,
    hazard_if.slave  bus
);
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        BR_FLUSH = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] stall_q, stall_d;
    logic [15:0] flush_q, flush_d;
    logic        lu_hit;
    logic        br_take;
    logic        pc_we, ifid_we, ifid_fl, idex_fl, freeze;

    assign lu_hit = bus.ex_wb_write_en & bus.ex_wb_data_sel & (bus.ex_wb_addr != 5'd0) &
                    ((bus.id_rs_used & (bus.id_rs == bus.ex_wb_addr)) |
                     (bus.id_rt_used & (bus.id_rt == bus.ex_wb_addr)));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pc_we   = 1'b1;
        ifid_we = 1'b1;
        ifid_fl = 1'b0;
        idex_fl = 1'b0;
        freeze  = 1'b0;
        br_take = 1'b0;
        if (bus.dmem_busy) begin
            freeze  = 1'b1;
            pc_we   = 1'b0;
            ifid_we = 1'b0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (bus.ex_PC_sel) begin
                        ifid_fl = 1'b1;
                        idex_fl = 1'b1;
                        br_take = 1'b1;
                        if (BRANCH_FLUSH > 1) begin
                            state_d = BR_FLUSH;
                            cnt_d   = 2'(BRANCH_FLUSH - 1);
                        end
                    end else if (lu_hit) begin
                        pc_we   = 1'b0;
                        ifid_we = 1'b0;
                        idex_fl = 1'b1;
                        if (LOAD_STALL > 1) begin
                            state_d = LU_STALL;
                            cnt_d   = 2'(LOAD_STALL - 1);
                        end
                    end
                end
                LU_STALL: begin
                    pc_we   = 1'b0;
                    ifid_we = 1'b0;
                    idex_fl = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = RUN;
                end
                BR_FLUSH: begin
                    ifid_fl = 1'b1;
                    idex_fl = 1'b1;
                    cnt_d   = cnt_q - 2'd1;
                    if (cnt_q == 2'd1) state_d = RUN;
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 2'd0;
                end
            endcase
        end
    end

    // A clear wins over an increment in the same cycle.
    always_comb begin
        stall_d = stall_q;
        flush_d = flush_q;
        if (bus.clr_stats) begin
            stall_d = 16'd0;
            flush_d = 16'd0;
        end else begin
            if (!pc_we && stall_q != 16'hFFFF) stall_d = stall_q + 16'd1;
            if (br_take && flush_q != 16'hFFFF) flush_d = flush_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= RUN;
            cnt_q   <= 2'd0;
            stall_q <= 16'd0;
            flush_q <= 16'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            stall_q <= stall_d;
            flush_q <= flush_d;
        end
    end

    assign bus.pc_write_en   = pc_we;
    assign bus.ifid_write_en = ifid_we;
    assign bus.ifid_flush    = ifid_fl;
    assign bus.idex_flush    = idex_fl;
    assign bus.pipe_freeze   = freeze;
    assign bus.hazard_state  = state_q;
    assign bus.stall_cycles  = stall_q;
    assign bus.flush_events  = flush_q;
endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter LOAD_STALL, default 1, range 1..3: bubble cycles inserted per load-use hazard.
REQ-002 Parameter BRANCH_FLUSH, default 2, range 1..3: flush cycles per taken branch/jump resolved in EX.
REQ-003 clk  in  1  clock, rising-edge.
REQ-004 reset  in  1  asynchronous, active-low.
REQ-005 id_rs, id_rt  in  5 each  source register numbers of the instruction in ID.
REQ-006 id_rs_used, id_rt_used  in  1 each  ID instruction reads rs / rt.
REQ-007 ex_wb_write_en, ex_wb_data_sel, ex_wb_addr  in  1/1/5  EX-stage write enable, writeback-data select (1 = load data), resolved destination.
REQ-008 ex_PC_sel  in  1  EX-stage branch/jump taken.
REQ-009 dmem_busy  in  1  data memory not ready; whole pipeline holds.
REQ-010 clr_stats  in  1  synchronous clear of the statistics counters.
REQ-011 pc_write_en, ifid_write_en  out  1 each  PC / IF-ID register update enables.
REQ-012 ifid_flush, idex_flush  out  1 each  load a bubble into IF-ID / ID-EX.
REQ-013 pipe_freeze  out  1  hold ID-EX, EX-MEM and MEM-WB registers.
REQ-014 hazard_state  out  2  FSM state: 0 RUN, 1 LU_STALL, 2 BR_FLUSH.
REQ-015 stall_cycles, flush_events  out  16 each  saturating statistics counters.

Function
REQ-016 Define lu_hit = ex_wb_write_en & ex_wb_data_sel & (ex_wb_addr != 0) & ((id_rs_used & id_rs == ex_wb_addr) | (id_rt_used & id_rt == ex_wb_addr)).
REQ-017 Priority in every state: dmem_busy > ex_PC_sel > lu_hit.
REQ-018 dmem_busy = 1 in any state: pipe_freeze = 1, pc_write_en = 0, ifid_write_en = 0, both flushes = 0; FSM state and internal down-counter hold.
REQ-019 RUN, no event: pc_write_en = 1, ifid_write_en = 1, flushes = 0, pipe_freeze = 0; remain in RUN.
REQ-020 RUN, ex_PC_sel = 1: pc_write_en = 1, ifid_write_en = 1, ifid_flush = 1, idex_flush = 1 in the same cycle (combinational); next state BR_FLUSH with count = BRANCH_FLUSH-1 if BRANCH_FLUSH > 1, else RUN; flush_events increments once.
REQ-021 RUN, lu_hit = 1 (no ex_PC_sel): pc_write_en = 0, ifid_write_en = 0, idex_flush = 1, ifid_flush = 0 in the same cycle; next state LU_STALL with count = LOAD_STALL-1 if LOAD_STALL > 1, else RUN.
REQ-022 LU_STALL: outputs as REQ-021; count decrements each non-frozen cycle; return to RUN in the cycle after the one where count == 1; ex_PC_sel and lu_hit ignored.
REQ-023 BR_FLUSH: pc_write_en = 1, ifid_write_en = 1, ifid_flush = 1, idex_flush = 1; count decrements as in REQ-022; ex_PC_sel and lu_hit ignored.
REQ-024 Resulting bubble totals: LOAD_STALL bubbles per load-use; BRANCH_FLUSH flush cycles per taken branch.
REQ-025 stall_cycles increments on each cycle with pc_write_en = 0; saturates at 16'hFFFF; no wrap.
REQ-026 flush_events saturates at 16'hFFFF; no wrap.
REQ-027 clr_stats = 1 zeroes both counters at the next edge, overriding any increment in that cycle; FSM unaffected.
REQ-028 All control outputs are combinational from state and inputs; state, count and counters are registered.

Reset
REQ-029 reset = 0 forces asynchronously: state RUN (hazard_state = 0), count 0, stall_cycles = 0, flush_events = 0.
REQ-030 During reset, control outputs follow RUN decoding of current inputs.
REQ-031 Reset asserted mid-stall or mid-flush abandons the sequence; first cycle after release is RUN.

Verification
REQ-032 Load-use, LOAD_STALL = 1: ex_wb_write_en = 1, ex_wb_data_sel = 1, ex_wb_addr = 5, id_rs = 5, id_rs_used = 1 -> 1 cycle pc_write_en = 0, idex_flush = 1; stall_cycles = 1.
REQ-033 Register 0 and unused source: ex_wb_addr = 0 matching id_rs = 0, or id_rt = 5 with id_rt_used = 0 -> no stall.
REQ-034 Taken branch, BRANCH_FLUSH = 2: ex_PC_sel = 1 for one cycle -> ifid_flush = idex_flush = 1 for exactly 2 cycles; hazard_state sequence 0, 2, 0; flush_events = 1.
REQ-035 Simultaneous events: dmem_busy = 1 together with ex_PC_sel = 1 and lu_hit = 1 for 3 cycles -> pipe_freeze = 1, no flush, state 0 held; branch flush starts on the first cycle after dmem_busy drops, if ex_PC_sel is still 1.
REQ-036 Saturation and clear: 70000 forced stall cycles -> stall_cycles = 16'hFFFF; clr_stats pulse -> 0 next cycle.
REQ-037 Reset mid-operation: LOAD_STALL = 3, reset asserted in the second stall cycle -> hazard_state = 0 and counters = 0 immediately; normal operation after release.
